// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: pulses PLL reset, waits for and qualifies lock, retries, then releases ready or latches fail
module pll_lock_sequencer #(
  parameter int RST_PULSE_CYCLES = 16,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES = 3
) (
  input  logic refclk,
  input  logic rst_n,
  input  logic restart,
  input  logic locked,
  output logic pll_rst,
  output logic ready,
  output logic fail,
  output logic lock_lost,
  output logic [$clog2(MAX_RETRIES+1)-1:0] retry_cnt
);
  localparam int MAX_A = RST_PULSE_CYCLES > STABLE_CYCLES ? RST_PULSE_CYCLES : STABLE_CYCLES;
  localparam int MAX_P = LOCK_TIMEOUT > MAX_A ? LOCK_TIMEOUT : MAX_A;
  localparam int CW = $clog2(MAX_P) + 1;
  localparam int RW = $clog2(MAX_RETRIES + 1);
  localparam logic [2:0] RESET_PLL = 3'd0, WAIT_LOCK = 3'd1, STABLE = 3'd2, RUN = 3'd3, FAILED = 3'd4;
  logic [2:0] state, state_n, fail_dst;
  logic [CW-1:0] cnt;
  logic [1:0] sync;
  logic locked_s, pulse_done, timeout, stable_done, attempt_fail;
  logic [RW-1:0] retry_n;
  assign locked_s = sync[1];
  // restart outranks every other event; a failed attempt either retries or parks in FAILED
  always_comb begin
    pulse_done = cnt == CW'(RST_PULSE_CYCLES - 1);
    timeout = cnt == CW'(LOCK_TIMEOUT - 1);
    stable_done = cnt == CW'(STABLE_CYCLES - 1);
    fail_dst = retry_cnt == RW'(MAX_RETRIES) ? FAILED : RESET_PLL;
    attempt_fail = !locked_s && ((state == WAIT_LOCK && timeout) || state == STABLE);
    state_n = restart ? RESET_PLL :
              state == RESET_PLL ? (pulse_done ? WAIT_LOCK : RESET_PLL) :
              state == WAIT_LOCK ? (locked_s ? STABLE : timeout ? fail_dst : WAIT_LOCK) :
              state == STABLE ? (!locked_s ? fail_dst : stable_done ? RUN : STABLE) :
              state == RUN ? (locked_s ? RUN : RESET_PLL) :
              state == FAILED ? FAILED : RESET_PLL;
    retry_n = restart || state_n == RUN ? '0 :
              attempt_fail && state_n == RESET_PLL ? retry_cnt + 1'b1 : retry_cnt;
  end
  always_ff @(posedge refclk or negedge rst_n)
    if (!rst_n) begin
      state <= RESET_PLL;
      cnt <= '0;
      sync <= '0;
      pll_rst <= 1'b1;
      ready <= 1'b0;
      fail <= 1'b0;
      lock_lost <= 1'b0;
      retry_cnt <= '0;
    end else begin
      sync <= {sync[0], locked};
      state <= state_n;
      cnt <= restart || state_n != state || state == RUN || state == FAILED ? '0 : cnt + 1'b1;
      pll_rst <= state_n == RESET_PLL || state_n == FAILED;
      ready <= state_n == RUN;
      fail <= state_n == FAILED;
      lock_lost <= !restart && state == RUN && !locked_s;
      retry_cnt <= retry_n;
    end
endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb_pll_lock_sequencer: directed steps, expected output vectors queued per clock edge and checked on the falling edge
module tb_pll_lock_sequencer;
  logic refclk = 1'b0;
  logic rst_n, restart, locked;
  logic pll_rst, ready, fail, lock_lost;
  logic [1:0] retry_cnt;
  logic [5:0] obs;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  typedef struct { int c; string tag; logic [5:0] v; } exp_t;
  exp_t sb[$];
  exp_t e;
  // obs = {pll_rst, ready, fail, lock_lost, retry_cnt}
  assign obs = {pll_rst, ready, fail, lock_lost, retry_cnt};
  pll_lock_sequencer #(
    .RST_PULSE_CYCLES(4),
    .LOCK_TIMEOUT(20),
    .STABLE_CYCLES(8),
    .MAX_RETRIES(2)
  ) dut (
    .refclk(refclk),
    .rst_n(rst_n),
    .restart(restart),
    .locked(locked),
    .pll_rst(pll_rst),
    .ready(ready),
    .fail(fail),
    .lock_lost(lock_lost),
    .retry_cnt(retry_cnt)
  );
  always #10 refclk = ~refclk;
  always @(posedge refclk) cyc <= cyc + 1;
  always @(negedge refclk) begin
    while (sb.size() > 0 && sb[0].c <= cyc) begin
      e = sb.pop_front();
      checks++;
      assert (obs === e.v && e.c == cyc) else begin
        errors++;
        $error("FAIL %s @%0d: observed=%b expected=%b", e.tag, e.c, obs, e.v);
      end
    end
    checks++;
    assert (!(ready && pll_rst)) else begin
      errors++;
      $error("FAIL ready_pll_rst_excl @%0d: observed=%b%b expected=not both 1", cyc, ready, pll_rst);
    end
  end
  task automatic exp_at(input int c, input string tag, input logic [5:0] v);
    sb.push_back('{c, tag, v});
  endtask
  task automatic go();
    @(posedge refclk);
    #1;
  endtask
  task automatic wait_until(input int c);
    while (cyc < c) go();
  endtask
  task automatic chk_now(input string tag, input logic [5:0] v);
    checks++;
    assert (obs === v) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, v);
    end
  endtask
  initial begin
    int s, n, d, r, s2;
    rst_n = 1'b0;
    restart = 1'b0;
    locked = 1'b0;
    go();
    go();
    chk_now("reset_values", 6'b1_0_0_0_00);
    // 1: release reset, lock from the 6th edge
    rst_n = 1'b1;
    s = cyc;
    exp_at(s + 3, "t1_pll_rst_hi", 6'b1_0_0_0_00);
    exp_at(s + 4, "t1_pll_rst_lo", 6'b0_0_0_0_00);
    wait_until(s + 5);
    locked = 1'b1;
    n = cyc;
    exp_at(n + 10, "t1_not_ready", 6'b0_0_0_0_00);
    exp_at(n + 11, "t1_ready", 6'b0_1_0_0_00);
    wait_until(n + 14);
    // 3: one-cycle lock drop while in RUN
    d = cyc;
    locked = 1'b0;
    exp_at(d + 2, "t3_still_run", 6'b0_1_0_0_00);
    exp_at(d + 3, "t3_lock_lost", 6'b1_0_0_1_00);
    exp_at(d + 4, "t3_lost_single", 6'b1_0_0_0_00);
    go();
    locked = 1'b1;
    s = d + 3;
    exp_at(s + 3, "t3_pll_rst_hi", 6'b1_0_0_0_00);
    exp_at(s + 4, "t3_pll_rst_lo", 6'b0_0_0_0_00);
    exp_at(s + 12, "t3_not_ready", 6'b0_0_0_0_00);
    exp_at(s + 13, "t3_ready", 6'b0_1_0_0_00);
    wait_until(s + 15);
    // 4: lock drops mid-STABLE
    r = cyc;
    restart = 1'b1;
    exp_at(r + 1, "t4_restart", 6'b1_0_0_0_00);
    go();
    restart = 1'b0;
    s = r + 1;
    exp_at(s + 4, "t4_wait_lock", 6'b0_0_0_0_00);
    wait_until(s + 8);
    locked = 1'b0;
    exp_at(s + 10, "t4_stable_cnt5", 6'b0_0_0_0_00);
    exp_at(s + 11, "t4_retry1", 6'b1_0_0_0_01);
    exp_at(s + 12, "t4_no_lock_lost", 6'b1_0_0_0_01);
    wait_until(s + 11);
    locked = 1'b1;
    s2 = s + 11;
    exp_at(s2 + 4, "t4_wait2", 6'b0_0_0_0_01);
    exp_at(s2 + 12, "t4_not_ready", 6'b0_0_0_0_01);
    exp_at(s2 + 13, "t4_ready_clr", 6'b0_1_0_0_00);
    wait_until(s2 + 15);
    // 2: no lock at all, three timeouts then fail
    r = cyc;
    restart = 1'b1;
    locked = 1'b0;
    exp_at(r + 1, "t2_restart", 6'b1_0_0_0_00);
    go();
    restart = 1'b0;
    s = r + 1;
    exp_at(s + 3, "t2_pulse1_hi", 6'b1_0_0_0_00);
    exp_at(s + 4, "t2_pulse1_lo", 6'b0_0_0_0_00);
    exp_at(s + 23, "t2_wait1_end", 6'b0_0_0_0_00);
    exp_at(s + 24, "t2_timeout1", 6'b1_0_0_0_01);
    exp_at(s + 28, "t2_pulse2_lo", 6'b0_0_0_0_01);
    exp_at(s + 48, "t2_timeout2", 6'b1_0_0_0_10);
    exp_at(s + 52, "t2_pulse3_lo", 6'b0_0_0_0_10);
    exp_at(s + 71, "t2_wait3_end", 6'b0_0_0_0_10);
    exp_at(s + 72, "t2_fail", 6'b1_0_1_0_10);
    exp_at(s + 90, "t2_fail_held", 6'b1_0_1_0_10);
    wait_until(s + 90);
    // 5: restart out of FAIL with a healthy PLL
    r = cyc;
    restart = 1'b1;
    locked = 1'b1;
    exp_at(r + 1, "t5_restart", 6'b1_0_0_0_00);
    go();
    restart = 1'b0;
    s = r + 1;
    exp_at(s + 3, "t5_pll_rst_hi", 6'b1_0_0_0_00);
    exp_at(s + 4, "t5_pll_rst_lo", 6'b0_0_0_0_00);
    exp_at(s + 12, "t5_not_ready", 6'b0_0_0_0_00);
    exp_at(s + 13, "t5_ready", 6'b0_1_0_0_00);
    wait_until(s + 15);
    // 6: async reset mid-STABLE
    r = cyc;
    restart = 1'b1;
    exp_at(r + 1, "t6_restart", 6'b1_0_0_0_00);
    go();
    restart = 1'b0;
    s = r + 1;
    wait_until(s + 8);
    rst_n = 1'b0;
    #2;
    chk_now("t6_async_stable", 6'b1_0_0_0_00);
    go();
    rst_n = 1'b1;
    s = cyc;
    exp_at(s + 3, "t6_pll_rst_hi", 6'b1_0_0_0_00);
    exp_at(s + 4, "t6_pll_rst_lo", 6'b0_0_0_0_00);
    exp_at(s + 12, "t6_not_ready", 6'b0_0_0_0_00);
    exp_at(s + 13, "t6_ready", 6'b0_1_0_0_00);
    wait_until(s + 15);
    // async reset mid-RUN, then restart on the timeout edge, then restart held high
    rst_n = 1'b0;
    #2;
    chk_now("t6_async_run", 6'b1_0_0_0_00);
    locked = 1'b0;
    go();
    rst_n = 1'b1;
    s = cyc;
    exp_at(s + 23, "t6_wait_end", 6'b0_0_0_0_00);
    exp_at(s + 24, "t6_restart_wins", 6'b1_0_0_0_00);
    wait_until(s + 23);
    restart = 1'b1;
    go();
    restart = 1'b0;
    s2 = s + 24;
    exp_at(s2 + 4, "t6_wait_again", 6'b0_0_0_0_00);
    wait_until(s2 + 5);
    restart = 1'b1;
    exp_at(s2 + 10, "t6_restart_held", 6'b1_0_0_0_00);
    exp_at(s2 + 14, "t6_pulse_after_hold", 6'b1_0_0_0_00);
    exp_at(s2 + 15, "t6_pulse_end", 6'b0_0_0_0_00);
    repeat (6) go();
    restart = 1'b0;
    wait_until(s2 + 18);
    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain: observed=%0d pending expected=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
